bu_pred: RTL

- Next-generation branch unit: resolves conditional branches, JAL and JALR, and produces a 1-cycle registered result.
- Holds a pattern history table (PHT) of 2-bit saturating counters, which fetch reads combinationally for direction prediction.
- Compares each resolved branch against the prediction that travelled with it and raises a registered mispredict/redirect to the front end.
- Sits in execute, beside the ALU, with a valid/ready handshake on both sides.

---
 rtl/bu_pred.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bu_pred.sv
// bu_pred: execute-stage branch unit with a 2-bit saturating pattern history table.
// Resolves BEQ/BNE/BLT/BGE/JAL/JALR one cycle after acceptance, flags
// mispredict/misaligned targets, and serves fetch with a combinational lookup.
// Optional: define BU_PERF_CNT_EN to add perf_br_o / perf_mis_o event counters.
module bu_pred #(
    parameter int XLEN         = 32,
    parameter int PHT_ENTRIES  = 64,
    parameter int NB_OPERATION = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_v_i,
    output logic                    in_rdy_o,
    input  logic [NB_OPERATION-1:0] cmd_i,
    input  logic                    unsign_cmp_i,
    input  logic [XLEN-1:0]         rs1_data_i,
    input  logic [XLEN-1:0]         rs2_data_i,
    input  logic [XLEN-1:0]         immediat_i,
    input  logic [XLEN-1:0]         pc_data_i,
    input  logic                    pred_taken_i,
    input  logic [XLEN-1:0]         pred_pc_i,
    output logic                    out_v_o,
    input  logic                    out_rdy_i,
    output logic [XLEN-1:0]         data_o,
    output logic                    branch_v_o,
    output logic [XLEN-1:0]         pc_nxt_o,
    output logic                    mispredict_o,
    output logic                    misaligned_o,
    input  logic                    flush_i,
`ifdef BU_PERF_CNT_EN
    output logic [XLEN-1:0]         perf_br_o,
    output logic [XLEN-1:0]         perf_mis_o,
`endif
    input  logic [XLEN-1:0]         lookup_pc_i,
    output logic                    lookup_taken_o
);

    localparam int IDX_W = $clog2(PHT_ENTRIES);

    // One-hot command bit positions
    localparam int OP_BEQ  = 0;
    localparam int OP_BNE  = 1;
    localparam int OP_BLT  = 2;
    localparam int OP_BGE  = 3;
    localparam int OP_JAL  = 4;
    localparam int OP_JALR = 5;

    logic [XLEN:0]   ext1, ext2, diff;
    logic            lt, eq;
    logic            one_hot, is_cond, is_jalr, taken;
    logic [XLEN-1:0] base, sum, target, link, nxt;
    logic            mal, mis;
    logic            accept;

    logic            out_v_q, br_q, mis_q, mal_q;
    logic [XLEN-1:0] data_q, pc_q;

    logic [1:0]       pht [PHT_ENTRIES];
    logic [IDX_W-1:0] upd_idx, look_idx;
    logic [1:0]       cnt, cnt_nxt;
    logic             unused_lookup;

    assign in_rdy_o = ~out_v_q | out_rdy_i;
    // flush discards any same-cycle input, so it also blocks the PHT update
    assign accept   = in_v_i & in_rdy_o & ~flush_i;

    // Compare on XLEN+1 bits so one subtraction serves signed and unsigned
    always_comb begin
        ext1 = {(unsign_cmp_i ? 1'b0 : rs1_data_i[XLEN-1]), rs1_data_i};
        ext2 = {(unsign_cmp_i ? 1'b0 : rs2_data_i[XLEN-1]), rs2_data_i};
        diff = ext1 - ext2;
        lt   = diff[XLEN];
        eq   = (diff == '0);
    end

    // Direction decode; malformed commands resolve as a not-taken non-branch
    always_comb begin
        one_hot = $onehot(cmd_i);
        taken   = 1'b0;
        is_cond = 1'b0;
        is_jalr = 1'b0;
        if (one_hot) begin
            if (cmd_i[OP_BEQ]) begin
                taken   = eq;
                is_cond = 1'b1;
            end
            if (cmd_i[OP_BNE]) begin
                taken   = ~eq;
                is_cond = 1'b1;
            end
            if (cmd_i[OP_BLT]) begin
                taken   = lt;
                is_cond = 1'b1;
            end
            if (cmd_i[OP_BGE]) begin
                taken   = ~lt;
                is_cond = 1'b1;
            end
            if (cmd_i[OP_JAL]) taken = 1'b1;
            if (cmd_i[OP_JALR]) begin
                taken   = 1'b1;
                is_jalr = 1'b1;
            end
        end
    end

    // Target, next PC and redirect decision
    always_comb begin
        base   = is_jalr ? rs1_data_i : pc_data_i;
        sum    = base + immediat_i;
        target = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
        link   = pc_data_i + XLEN'(4);
        nxt    = taken ? target : link;
        mal    = taken & target[1];
        mis    = ~mal & ((taken != pred_taken_i) | (nxt != pred_pc_i));
    end

    // Result register: flush beats accept, accept beats drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
            br_q    <= 1'b0;
            mis_q   <= 1'b0;
            mal_q   <= 1'b0;
        end else if (flush_i) begin
            out_v_q <= 1'b0;
        end else if (accept) begin
            out_v_q <= 1'b1;
            data_q  <= link;
            pc_q    <= nxt;
            br_q    <= taken;
            mis_q   <= mis;
            mal_q   <= mal;
        end else if (out_rdy_i) begin
            out_v_q <= 1'b0;
        end
    end

    assign out_v_o      = out_v_q;
    assign data_o       = data_q;
    assign pc_nxt_o     = pc_q;
    assign branch_v_o   = br_q;
    assign mispredict_o = mis_q;
    assign misaligned_o = mal_q;

    assign upd_idx  = pc_data_i[IDX_W+1:2];
    assign look_idx = lookup_pc_i[IDX_W+1:2];

    // Saturating counter step for the branch being accepted
    always_comb begin
        cnt = pht[upd_idx];
        if (taken) cnt_nxt = (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else       cnt_nxt = (cnt == 2'b00) ? cnt : cnt - 2'd1;
    end

    // PHT storage: weakly not-taken after reset, conditional branches train it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
        end else if (accept && is_cond) begin
            pht[upd_idx] <= cnt_nxt;
        end
    end

    // Read-before-write: a same-cycle update is not visible to the lookup
    assign lookup_taken_o = pht[look_idx][1];
    assign unused_lookup  = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0]};

`ifdef BU_PERF_CNT_EN
    logic [XLEN-1:0] perf_br_q, perf_mis_q;

    // Event counters: accepted conditional branches and consumed mispredicts
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (accept && is_cond) perf_br_q <= perf_br_q + XLEN'(1);
            if (out_v_q && out_rdy_i && mis_q) perf_mis_q <= perf_mis_q + XLEN'(1);
        end
    end

    assign perf_br_o  = perf_br_q;
    assign perf_mis_o = perf_mis_q;
`endif

endmodule
